// File: rtl/toggle_meter_pkg.sv
// Shared types and defaults for the toggle period meter.
package toggle_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_EXPECT_HALF = 6;
    localparam int DEF_LOCK_COUNT  = 2;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/toggle_period_meter_sync_edge_detect.sv
// Two-flop synchronizer with dual-edge pulse output.
// GLITCH_FILTER_EN: level must hold two cycles before an edge is reported.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic toggle_edge
);

    logic sync_q1;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q  <= sync_q1;
        end
    end

`ifdef GLITCH_FILTER_EN
    logic stab_q;
    logic filt_q;
    logic filt_d;

    // filt_q only follows sync_q once it has matched the previous sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stab_q <= 1'b0;
            filt_q <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            stab_q <= sync_q;
            if (sync_q == stab_q)
                filt_q <= sync_q;
            filt_d <= filt_q;
        end
    end

    assign toggle_edge = filt_q ^ filt_d;
`else
    logic sync_q_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sync_q_d <= 1'b0;
        else
            sync_q_d <= sync_q;
    end

    assign toggle_edge = sync_q ^ sync_q_d;
`endif

endmodule

// File: rtl/toggle_period_meter.sv
// Half-period meter for an asynchronous toggle signal with lock detection.
// Optional GLITCH_FILTER_EN selects the filtered edge detector.
//
// state   | meaning
// IDLE    | waiting for the first edge to start an interval
// MEASURE | measuring, fewer than LOCK_COUNT consecutive matches
// LOCKED  | LOCK_COUNT or more consecutive matches of EXPECT_HALF
module toggle_period_meter
    import toggle_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int EXPECT_HALF = DEF_EXPECT_HALF,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             toggle_in,
    input  logic             clear,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             stall
);

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] EXP_V     = CNT_W'(EXPECT_HALF);
    localparam logic [3:0]       LOCK_V    = 4'(LOCK_COUNT);

    logic             toggle_edge;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       match_cnt, match_nx;
    logic [CNT_W-1:0] hp_nx;
    logic             pv_nx, mm_nx, st_nx;

    sync_edge_detect u_sync (
        .clk         (clk),
        .rst         (rst),
        .din         (toggle_in),
        .toggle_edge (toggle_edge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
            stall        <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            match_cnt    <= match_nx;
            half_period  <= hp_nx;
            period_valid <= pv_nx;
            mismatch     <= mm_nx;
            stall        <= st_nx;
            locked       <= (state_nx == LOCKED);
        end
    end

    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        hp_nx    = half_period;
        pv_nx    = 1'b0;
        mm_nx    = 1'b0;
        st_nx    = 1'b0;
        if (toggle_edge)
            cnt_nx = CNT_W'(1);
        else if (cnt == CNT_MAX_V)
            cnt_nx = cnt;
        else
            cnt_nx = cnt + CNT_W'(1);

        // clear wins over a coincident edge, which is dropped
        if (clear) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            match_nx = '0;
            hp_nx    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (toggle_edge)
                        state_nx = MEASURE;
                end
                MEASURE, LOCKED: begin
                    if (toggle_edge) begin
                        hp_nx = cnt;
                        pv_nx = 1'b1;
                        if (cnt == EXP_V) begin
                            if (match_cnt < LOCK_V)
                                match_nx = match_cnt + 4'd1;
                            state_nx = (match_nx == LOCK_V) ? LOCKED : MEASURE;
                        end else begin
                            mm_nx    = 1'b1;
                            match_nx = '0;
                            state_nx = MEASURE;
                        end
                    end else if (cnt == CNT_MAX_V) begin
                        st_nx    = 1'b1;
                        match_nx = '0;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
